// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: run-control, redirect and fetch/execute PC signals of the program counter sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 8
);
  logic                    start;
  logic [ADDR_WIDTH-1:0]   start_pc;
  logic                    en;
  logic                    jump_reg;
  logic [ADDR_WIDTH-1:0]   jr_pc;
  logic                    branch;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic                    halt;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    pc_valid;
  logic [ADDR_WIDTH-1:0]   pc_ex;
  logic                    pc_ex_valid;
  logic                    flush;
  logic                    busy;
  logic                    done;
  modport master (
    output start, start_pc, en, jump_reg, jr_pc, branch, branch_offset, halt,
    input  pc, pc_valid, pc_ex, pc_ex_valid, flush, busy, done
  );
  modport slave (
    input  start, start_pc, en, jump_reg, jr_pc, branch, branch_offset, halt,
    output pc, pc_valid, pc_ex, pc_ex_valid, flush, busy, done
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC with start/halt control, jump/branch redirects and an execute-stage PC delay line.
module pc_sequencer #(
  parameter int              ADDR_WIDTH   = 8,
  parameter int              OFFSET_WIDTH = 8,
  parameter int              PC_DELAY     = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e                               state_q, state_d;
  logic [ADDR_WIDTH-1:0]                pc_q, pc_d;
  logic                                 pc_valid_q, pc_valid_d;
  logic [PC_DELAY-1:0][ADDR_WIDTH-1:0]  stg_pc_q, stg_pc_d;
  logic [PC_DELAY-1:0]                  stg_v_q, stg_v_d;
  logic                                 done_q;
  logic                                 busy, act, do_halt, redir;
  logic signed [ADDR_WIDTH-1:0]         off_ext;
  assign busy    = state_q == RUN;
  assign act     = bus.en && busy && stg_v_q[PC_DELAY-1];
  assign do_halt = act && bus.halt;
  assign redir   = act && !bus.halt && (bus.jump_reg || bus.branch);
  assign off_ext = $signed(bus.branch_offset);
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    stg_pc_d   = stg_pc_q;
    stg_v_d    = stg_v_q;
    if (!busy && bus.start) begin
      state_d    = RUN;
      pc_d       = bus.start_pc;
      pc_valid_d = 1'b1;
      stg_v_d    = '0;
    end else if (busy && bus.en) begin
      stg_pc_d[0] = pc_q;
      stg_v_d[0]  = pc_valid_q;
      for (int k = 1; k < PC_DELAY; k++) begin
        stg_pc_d[k] = stg_pc_q[k-1];
        stg_v_d[k]  = stg_v_q[k-1];
      end
      state_d    = do_halt ? IDLE : RUN;
      pc_valid_d = !do_halt;
      stg_v_d    = (do_halt || redir) ? '0 : stg_v_d;
      pc_d       = do_halt ? pc_q :
                   !redir  ? pc_q + 1'b1 :
                   bus.jump_reg ? bus.jr_pc : stg_pc_q[PC_DELAY-1] + off_ext;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      stg_pc_q   <= '0;
      stg_v_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      stg_pc_q   <= stg_pc_d;
      stg_v_q    <= stg_v_d;
      done_q     <= do_halt;
    end
  end
  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pc_ex       = stg_pc_q[PC_DELAY-1];
  assign bus.pc_ex_valid = stg_v_q[PC_DELAY-1];
  assign bus.flush       = redir;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed run of start, branch/jump wrap, stall, halt and reset scenarios with hand-computed expectations.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  pc_sequencer_if #(.ADDR_WIDTH(8), .OFFSET_WIDTH(8)) bus ();
  pc_sequencer #(.ADDR_WIDTH(8), .OFFSET_WIDTH(8), .PC_DELAY(2), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_pc(input string tag, input logic [7:0] pc, input logic [7:0] pc_ex, input logic pc_ex_valid);
    chk({tag, " pc"}, 32'(bus.pc), 32'(pc));
    chk({tag, " pc_ex_valid"}, 32'(bus.pc_ex_valid), 32'(pc_ex_valid));
    if (pc_ex_valid) chk({tag, " pc_ex"}, 32'(bus.pc_ex), 32'(pc_ex));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0; bus.start_pc = 0; bus.en = 0; bus.jump_reg = 0; bus.jr_pc = 0;
    bus.branch = 0; bus.branch_offset = 0; bus.halt = 0;
    tick(); tick();
    rst = 0;
    chk("rst pc", 32'(bus.pc), 32'h00);
    chk("rst pc_valid", 32'(bus.pc_valid), 0);
    chk("rst pc_ex", 32'(bus.pc_ex), 0);
    chk("rst pc_ex_valid", 32'(bus.pc_ex_valid), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst flush", 32'(bus.flush), 0);
    // start at 0x10
    bus.start = 1; bus.start_pc = 8'h10; bus.en = 1;
    tick(); bus.start = 0;
    chk("start busy", 32'(bus.busy), 1);
    chk("start pc_valid", 32'(bus.pc_valid), 1);
    chk_pc("start c0", 8'h10, 8'h00, 0);
    tick(); chk_pc("start c1", 8'h11, 8'h00, 0);
    tick(); chk_pc("start c2", 8'h12, 8'h10, 1);
    tick(); chk_pc("seq c3", 8'h13, 8'h11, 1);
    tick(); chk_pc("seq c4", 8'h14, 8'h12, 1);
    // branch -4 from pc_ex 0x12
    bus.branch = 1; bus.branch_offset = 8'hFC; #1;
    chk("branch flush", 32'(bus.flush), 1);
    tick();
    chk_pc("branch tgt", 8'h0E, 8'h00, 0);
    chk("branch squash flush", 32'(bus.flush), 0);
    bus.branch = 0;
    tick(); chk_pc("branch b1", 8'h0F, 8'h00, 0);
    tick(); chk_pc("branch b2", 8'h10, 8'h0E, 1);
    // jump to 0xFF then wrap
    bus.jump_reg = 1; bus.jr_pc = 8'hFF; #1;
    chk("jr flush", 32'(bus.flush), 1);
    tick(); bus.jump_reg = 0;
    chk_pc("jr tgt", 8'hFF, 8'h00, 0);
    tick(); chk_pc("jr wrap", 8'h00, 8'h00, 0);
    tick(); chk_pc("jr ex", 8'h01, 8'hFF, 1);
    tick(); tick(); tick();
    chk_pc("pre br wrap", 8'h04, 8'h02, 1);
    bus.branch = 1; bus.branch_offset = 8'hFD;
    tick(); bus.branch = 0;
    chk_pc("br wrap", 8'hFF, 8'h00, 0);
    tick(); tick();
    chk_pc("br wrap ex", 8'h01, 8'hFF, 1);
    // stall with branch held
    bus.en = 0; bus.branch = 1; bus.branch_offset = 8'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall flush", 32'(bus.flush), 0);
      tick();
      chk_pc("stall", 8'h01, 8'hFF, 1);
      chk("stall pc_valid", 32'(bus.pc_valid), 1);
    end
    bus.en = 1; bus.branch = 0;
    tick(); chk_pc("resume", 8'h02, 8'h00, 1);
    // jump_reg beats branch
    bus.jump_reg = 1; bus.branch = 1; bus.jr_pc = 8'h40; bus.branch_offset = 8'h10; #1;
    chk("jr+br flush", 32'(bus.flush), 1);
    tick(); bus.jump_reg = 0; bus.branch = 0;
    chk_pc("jr+br", 8'h40, 8'h00, 0);
    tick(); tick();
    chk_pc("pre halt", 8'h42, 8'h40, 1);
    // halt beats branch
    bus.halt = 1; bus.branch = 1; #1;
    chk("halt flush", 32'(bus.flush), 0);
    tick(); bus.halt = 0; bus.branch = 0;
    chk("halt done", 32'(bus.done), 1);
    chk("halt busy", 32'(bus.busy), 0);
    chk("halt pc_valid", 32'(bus.pc_valid), 0);
    chk_pc("halt", 8'h42, 8'h00, 0);
    tick();
    chk("done pulse", 32'(bus.done), 0);
    chk("idle pc", 32'(bus.pc), 32'h42);
    // run again, then reset concurrent with start
    bus.start = 1; bus.start_pc = 8'h20;
    tick(); bus.start = 0;
    chk_pc("restart", 8'h20, 8'h00, 0);
    tick(); tick();
    chk_pc("restart ex", 8'h22, 8'h20, 1);
    bus.start = 1; bus.start_pc = 8'h55; bus.jump_reg = 1; bus.jr_pc = 8'h99; rst = 1;
    tick(); rst = 0; bus.jump_reg = 0;
    chk("mid rst pc", 32'(bus.pc), 32'h00);
    chk("mid rst busy", 32'(bus.busy), 0);
    chk("mid rst pc_valid", 32'(bus.pc_valid), 0);
    chk("mid rst pc_ex_valid", 32'(bus.pc_ex_valid), 0);
    chk("mid rst pc_ex", 32'(bus.pc_ex), 0);
    tick(); bus.start = 0;
    chk_pc("post rst start", 8'h55, 8'h00, 0);
    chk("post rst busy", 32'(bus.busy), 1);
    // halt on a squashed slot is ignored
    bus.halt = 1;
    tick(); bus.halt = 0;
    chk("squashed halt busy", 32'(bus.busy), 1);
    chk("squashed halt done", 32'(bus.done), 0);
    chk_pc("squashed halt", 8'h56, 8'h00, 0);
    tick(); chk_pc("post rst ex", 8'h57, 8'h55, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
